setbit_iterator: RTL and testbench

SETBIT_ITERATOR -- requirements
Module: setbit_iterator

---
 rtl/setbit_iterator_if.sv | 36 +++
 rtl/setbit_iterator.sv | 84 ++++++++
 tb/tb_setbit_iterator.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/setbit_iterator_if.sv
// Handshake bundle for setbit_iterator: word-in channel and index-out beat channel.
// pop_count exists only when SETBIT_ITER_POPCNT_EN is defined.
interface setbit_iterator_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int PW = $clog2(DATA_WIDTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IW-1:0]         out_index;
    logic                  out_last;
    logic                  out_empty;
`ifdef SETBIT_ITER_POPCNT_EN
    logic [PW-1:0]         pop_count;
`endif

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_last, out_empty
`ifdef SETBIT_ITER_POPCNT_EN
        , output pop_count
`endif
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_empty
`ifdef SETBIT_ITER_POPCNT_EN
        , input pop_count
`endif
    );
endinterface

// File: rtl/setbit_iterator.sv
// Enumerates the set bits of an accepted word, lowest first, one beat per cycle.
// Optional feature: define SETBIT_ITER_POPCNT_EN to add a registered pop_count output.
module setbit_iterator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    setbit_iterator_if.slave  bus
);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int PW = $clog2(DATA_WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] mask_dec;
    logic                  empty_q;
    logic [IW-1:0]         ctz;
    logic                  single;
    logic                  last;

    // Lowest set bit wins because the scan runs MSB to LSB; an all-zero mask gives 0.
    always_comb begin
        ctz = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            if (mask[i]) ctz = IW'(i);
    end

    assign mask_dec = mask - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign single   = (mask != '0) && ((mask & mask_dec) == '0);
    assign last     = empty_q || single;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_index = ctz;
    assign bus.out_last  = (state == EMIT) && last;
    assign bus.out_empty = (state == EMIT) && empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mask    <= '0;
            empty_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    mask    <= bus.in_data;
                    empty_q <= (bus.in_data == '0);
                    state   <= EMIT;
                end
                default: if (bus.out_ready) begin
                    // x & (x-1) drops exactly the bit reported on out_index
                    mask <= mask & mask_dec;
                    if (last) begin
                        state   <= IDLE;
                        empty_q <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef SETBIT_ITER_POPCNT_EN
    logic [PW-1:0] pop_q;
    logic [PW-1:0] pop_in;

    always_comb begin
        pop_in = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            pop_in = pop_in + PW'(bus.in_data[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            pop_q <= '0;
        else if (state == IDLE && bus.in_valid)
            pop_q <= pop_in;
    end

    assign bus.pop_count = pop_q;
`endif
endmodule

// File: tb/tb_setbit_iterator.sv
// Directed bench for setbit_iterator: inputs change and outputs are checked on the falling edge.
module tb_setbit_iterator;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    setbit_iterator_if #(.DATA_WIDTH(8)) bif ();

    setbit_iterator #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input int idx, input logic lst, input logic emp);
        chk({tag, "_valid"}, 64'(bif.out_valid), 64'd1);
        chk({tag, "_ready"}, 64'(bif.in_ready),  64'd0);
        chk({tag, "_index"}, 64'(bif.out_index), 64'(idx));
        chk({tag, "_last"},  64'(bif.out_last),  64'(lst));
        chk({tag, "_empty"}, 64'(bif.out_empty), 64'(emp));
    endtask

    task automatic idle(input string tag);
        chk({tag, "_ready"}, 64'(bif.in_ready),  64'd1);
        chk({tag, "_valid"}, 64'(bif.out_valid), 64'd0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] w);
        bif.in_valid = 1'b1;
        bif.in_data  = w;
        tick();
        bif.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.out_ready = 1'b1;
        tick();
        tick();
        idle("rst");
        chk("rst_index", 64'(bif.out_index), 64'd0);
        chk("rst_last",  64'(bif.out_last),  64'd0);
        chk("rst_empty", 64'(bif.out_empty), 64'd0);
`ifdef SETBIT_ITER_POPCNT_EN
        chk("rst_pop", 64'(bif.pop_count), 64'd0);
`endif
        rst = 1'b0;

        // two bits: 0 then 4 (last), idle right after
        send(8'b0001_0001);
        beat("w11_b0", 0, 1'b0, 1'b0);
        tick();
        beat("w11_b4", 4, 1'b1, 1'b0);
        tick();
        idle("w11_done");
`ifdef SETBIT_ITER_POPCNT_EN
        chk("w11_pop", 64'(bif.pop_count), 64'd2);
`endif

        // zero word: single empty beat
        send(8'h00);
        beat("w00", 0, 1'b1, 1'b1);
        tick();
        idle("w00_done");
`ifdef SETBIT_ITER_POPCNT_EN
        chk("w00_pop", 64'(bif.pop_count), 64'd0);
`endif

        // backpressure on the first beat holds index 2 stable
        send(8'b1010_0100);
        bif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat("wa4_stall", 2, 1'b0, 1'b0);
            tick();
        end
        beat("wa4_b2", 2, 1'b0, 1'b0);
        bif.out_ready = 1'b1;
        tick();
        beat("wa4_b5", 5, 1'b0, 1'b0);
        tick();
        beat("wa4_b7", 7, 1'b1, 1'b0);
        tick();
        idle("wa4_done");
`ifdef SETBIT_ITER_POPCNT_EN
        chk("wa4_pop", 64'(bif.pop_count), 64'd3);
`endif

        // all ones: eight back-to-back beats
        send(8'hFF);
        for (int i = 0; i < 8; i++) begin
            beat("wff", i, (i == 7), 1'b0);
            tick();
        end
        idle("wff_done");
`ifdef SETBIT_ITER_POPCNT_EN
        chk("wff_pop", 64'(bif.pop_count), 64'd8);
`endif

        // reset mid-word wins over the pending handshake; bit 7 never appears
        send(8'b1001_0000);
        beat("w90_b4", 4, 1'b0, 1'b0);
        tick();
        beat("w90_b7_pending", 7, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle("w90_rst");
        chk("w90_rst_index", 64'(bif.out_index), 64'd0);
        chk("w90_rst_last",  64'(bif.out_last),  64'd0);
        tick();
        idle("w90_quiet");

        // reset beats a simultaneous accept
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h0F;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bif.in_valid = 1'b0;
        idle("rst_vs_accept");

        // a new word offered during EMIT waits for IDLE
        send(8'b0000_0011);
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h80;
        beat("w03_b0", 0, 1'b0, 1'b0);
        tick();
        beat("w03_b1", 1, 1'b1, 1'b0);
        tick();
        idle("w03_gap");
        tick();
        bif.in_valid = 1'b0;
        beat("w80_b7", 7, 1'b1, 1'b0);
`ifdef SETBIT_ITER_POPCNT_EN
        chk("w80_pop", 64'(bif.pop_count), 64'd1);
`endif
        tick();
        idle("w80_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
